// File: rtl/vga_sync_monitor.sv
// VGA receive-side sync monitor: recovers pixel coordinates from
// h/v sync, checks 640x480-style timing, declares lock, emits pixels.
module vga_sync_monitor #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_LEVEL  = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [3:0] in_r,
  input  logic [3:0] in_g,
  input  logic [3:0] in_b,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [3:0] pix_r,
  output logic [3:0] pix_g,
  output logic [3:0] pix_b,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err
);

  localparam logic [9:0] HTOT_M1 =
    10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VTOT_M1 =
    10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HSW  = 10'(H_SYNC);
  localparam logic [9:0] X0   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] X1   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] Y0   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] Y1   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] CMAX = 10'd1023;
  localparam logic [7:0] LOCKN = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH, HSYNC, TRACK, LOCKED
  } state_e;

  logic       hs_q, vs_q, hs_p_q, vs_p_q;
  logic [3:0] r_q, g_q, b_q;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic       vpend_q, vpend_d;
  logic       hseen_q, hseen_d, vseen_q, vseen_d;
  logic       bad_q, bad_d;
  logic [7:0] good_q, good_d, gnext;
  state_e     state_q, state_d;

  logic       h_on, h_on_p, v_on, v_on_p;
  logic       h_rise, h_fall, v_rise, vclr, wd;
  logic       herr, verr, err;
  logic       win, lock_d, valid_d;
  logic [9:0] px, py;

  logic       valid_q, fs_q, locked_q, herr_q, verr_q;
  logic [9:0] x_q, y_q;
  logic [3:0] pr_q, pg_q, pb_q;

  assign h_on   = (hs_q == SYNC_LEVEL);
  assign h_on_p = (hs_p_q == SYNC_LEVEL);
  assign v_on   = (vs_q == SYNC_LEVEL);
  assign v_on_p = (vs_p_q == SYNC_LEVEL);
  assign h_rise = h_on & ~h_on_p;
  assign h_fall = ~h_on & h_on_p;
  assign v_rise = v_on & ~v_on_p;
  assign vclr   = h_rise & (vpend_q | v_rise);
  assign wd     = ~h_rise & (hcnt_q == CMAX - 10'd1);

  // Counters, sync bookkeeping and timing checks for the current sample.
  always_comb begin
    hcnt_d = (hcnt_q == CMAX) ? CMAX : hcnt_q + 10'd1;
    if (h_rise) hcnt_d = '0;
    vcnt_d = vcnt_q;
    if (vclr) vcnt_d = '0;
    else if (h_rise && vcnt_q != CMAX) vcnt_d = vcnt_q + 10'd1;
    vpend_d = vclr ? 1'b0 : (vpend_q | v_rise);
    hseen_d = wd ? 1'b0 : (hseen_q | h_rise);
    vseen_d = wd ? 1'b0 : (vseen_q | vclr);
    herr = (h_rise & hseen_q & (hcnt_q != HTOT_M1))
         | (h_fall & (hcnt_d != HSW))
         | wd;
    verr = vclr & vseen_q & (vcnt_q != VTOT_M1);
    err  = herr | verr;
    bad_d = vclr ? 1'b0 : (bad_q | err);
  end

  // Lock state machine: next state and good-frame count.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    gnext   = good_q + 8'd1;
    unique case (state_q)
      SEARCH: if (h_rise) state_d = HSYNC;
      HSYNC: begin
        if (vclr) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK: begin
        if (err || (vclr && bad_q)) begin
          good_d = '0;
        end else if (vclr) begin
          good_d = gnext;
          if (gnext >= LOCKN) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (err) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
    endcase
    if (wd) begin
      state_d = SEARCH;
      good_d  = '0;
    end
  end

  // Active-window decode on the count belonging to the current sample.
  always_comb begin
    win = (hcnt_d >= X0) && (hcnt_d <= X1) &&
          (vcnt_d >= Y0) && (vcnt_d <= Y1);
    lock_d  = (state_d == LOCKED);
    valid_d = lock_d & win;
    px = hcnt_d - X0;
    py = vcnt_d - Y0;
  end

  // Input capture plus the previous registered sync for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q   <= ~SYNC_LEVEL;
      vs_q   <= ~SYNC_LEVEL;
      hs_p_q <= ~SYNC_LEVEL;
      vs_p_q <= ~SYNC_LEVEL;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      hs_q   <= h_sync;
      vs_q   <= v_sync;
      hs_p_q <= hs_q;
      vs_p_q <= vs_q;
      r_q    <= in_r;
      g_q    <= in_g;
      b_q    <= in_b;
    end
  end

  // Counter, flag and FSM state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      vpend_q <= 1'b0;
      hseen_q <= 1'b0;
      vseen_q <= 1'b0;
      bad_q   <= 1'b0;
      good_q  <= '0;
      state_q <= SEARCH;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      vpend_q <= vpend_d;
      hseen_q <= hseen_d;
      vseen_q <= vseen_d;
      bad_q   <= bad_d;
      good_q  <= good_d;
      state_q <= state_d;
    end
  end

  // Output register; coordinates and colour hold outside valid pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      herr_q   <= 1'b0;
      verr_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      pr_q     <= '0;
      pg_q     <= '0;
      pb_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      fs_q     <= valid_d && (px == '0) && (py == '0);
      locked_q <= lock_d;
      herr_q   <= herr;
      verr_q   <= verr;
      if (valid_d) begin
        x_q  <= px;
        y_q  <= py;
        pr_q <= r_q;
        pg_q <= g_q;
        pb_q <= b_q;
      end
    end
  end

  assign pix_valid   = valid_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign pix_r       = pr_q;
  assign pix_g       = pg_q;
  assign pix_b       = pb_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign h_err       = herr_q;
  assign v_err       = verr_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a reduced 8x4 raster
// (16 clocks per line, 9 lines per frame).
module tb_vga_sync_monitor;

  logic       clk, reset, h_sync, v_sync;
  logic [3:0] in_r, in_g, in_b;
  logic       pix_valid, frame_start, locked, h_err, v_err;
  logic [9:0] pix_x, pix_y;
  logic [3:0] pix_r, pix_g, pix_b;

  vga_sync_monitor #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_LEVEL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .h_sync(h_sync), .v_sync(v_sync),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .locked(locked),
    .h_err(h_err), .v_err(v_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int n_valid = 0, n_fs = 0, n_bad = 0, n_he = 0, n_ve = 0;
  int herr_cyc = 0, verr_cyc = 0, lock_cyc = 0, unlock_cyc = 0;
  int fs_cyc = 0;
  logic lk_prev = 1'b0;
  logic [9:0] ex = '0, ey = '0;
  int tl [0:8];
  int t_idle, b_v, b_f, b_b, b_h, b_e;

  // Output monitor: event counts/times and raster-order pixel check.
  always @(negedge clk) begin
    if (h_err === 1'b1) begin
      n_he <= n_he + 1;
      herr_cyc <= cyc;
    end
    if (v_err === 1'b1) begin
      n_ve <= n_ve + 1;
      verr_cyc <= cyc;
    end
    if (locked === 1'b1 && lk_prev !== 1'b1) lock_cyc <= cyc;
    if (locked !== 1'b1 && lk_prev === 1'b1) unlock_cyc <= cyc;
    lk_prev <= locked;
    if (frame_start === 1'b1) begin
      n_fs <= n_fs + 1;
      fs_cyc <= cyc;
    end
    if (pix_valid === 1'b1) begin
      n_valid <= n_valid + 1;
      if (pix_x !== ex || pix_y !== ey ||
          pix_r !== ex[3:0] || pix_g !== ey[3:0] ||
          pix_b !== ex[7:4] ||
          frame_start !== (ex == 0 && ey == 0))
        n_bad <= n_bad + 1;
    end else if (frame_start !== 1'b0) begin
      n_bad <= n_bad + 1;
    end
    if (locked !== 1'b1) begin
      ex <= '0;
      ey <= '0;
    end else if (pix_valid === 1'b1) begin
      ex <= (ex == 10'd7) ? 10'd0 : ex + 10'd1;
      if (ex == 10'd7) ey <= (ey == 10'd3) ? 10'd0 : ey + 10'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One line: l = line index in frame, len clocks, sw clocks of h sync.
  task automatic line(input int l, input int len, input int sw);
    logic [9:0] x, y;
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      if (c == 0) tl[l] = cyc;
      h_sync = (c < sw) ? 1'b0 : 1'b1;
      v_sync = (l < 2) ? 1'b0 : 1'b1;
      if (l >= 4 && l < 8 && c >= 6 && c < 14) begin
        x = 10'(c - 6);
        y = 10'(l - 4);
        in_r = x[3:0];
        in_g = y[3:0];
        in_b = x[7:4];
      end else begin
        in_r = 4'hA;
        in_g = 4'h5;
        in_b = 4'hC;
      end
    end
  endtask

  // A frame of nl lines; line bl gets length blen and sync width bsw.
  task automatic frame(input int nl, input int bl,
                       input int blen, input int bsw);
    for (int l = 0; l < nl; l++)
      line(l, (l == bl) ? blen : 16, (l == bl) ? bsw : 3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) t_idle = cyc;
      h_sync = 1'b1;
      v_sync = 1'b1;
      in_r = 4'h3;
      in_g = 4'h3;
      in_b = 4'h3;
    end
  endtask

  task automatic snap();
    b_v = n_valid;
    b_f = n_fs;
    b_b = n_bad;
    b_h = n_he;
    b_e = n_ve;
  endtask

  initial begin
    reset = 1'b0;
    h_sync = 1'b1;
    v_sync = 1'b1;
    in_r = '0;
    in_g = '0;
    in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_xy", 32'({pix_x, pix_y}), 0);
    chk("rst_rgb", 32'({pix_r, pix_g, pix_b}), 0);
    chk("rst_flags", 32'({locked, frame_start, h_err, v_err}), 0);
    reset = 1'b1;

    // Two blank lines, then F0 (first v edge), F1, F2 (locks at start).
    line(8, 16, 3);
    line(8, 16, 3);
    frame(9, -1, 0, 0);
    frame(9, -1, 0, 0);
    chk("no_lock_early", 32'(locked), 0);
    snap();
    frame(9, -1, 0, 0);
    chk("lock_time", lock_cyc, tl[0] + 2);
    chk("locked_f2", 32'(locked), 1);
    chk("valid_cnt_f2", n_valid - b_v, 32);
    chk("fs_cnt_f2", n_fs - b_f, 1);
    chk("fs_time", fs_cyc, tl[0] + 72);
    chk("pix_bad_f2", n_bad - b_b, 0);
    chk("last_xy", 32'({pix_x, pix_y}), 32'({10'd7, 10'd3}));
    chk("no_err_f2", (n_he - b_h) + (n_ve - b_e), 0);

    // Short line (15 clocks) on line 5 while locked.
    snap();
    frame(9, 5, 15, 3);
    chk("short_herr_cnt", n_he - b_h, 1);
    chk("short_herr_time", herr_cyc, tl[6] + 2);
    chk("short_unlock", unlock_cyc, herr_cyc);
    chk("short_valid", n_valid - b_v, 16);
    snap();
    frame(9, -1, 0, 0);
    frame(9, -1, 0, 0);
    chk("relock_gap_valid", n_valid - b_v, 0);
    chk("relock_gap_lock", 32'(locked), 0);
    snap();
    frame(9, -1, 0, 0);
    chk("relock_time", lock_cyc, tl[0] + 2);
    chk("relock_valid", n_valid - b_v, 32);
    chk("relock_pix_bad", n_bad - b_b, 0);

    // Narrow h sync (2 clocks) on line 3.
    snap();
    frame(9, 3, 16, 2);
    chk("hsw_herr_cnt", n_he - b_h, 1);
    chk("hsw_herr_time", herr_cyc, tl[3] + 4);
    chk("hsw_unlock", unlock_cyc, herr_cyc);

    // Frame one line short: v_err at the next clear, count restarts.
    snap();
    frame(8, -1, 0, 0);
    frame(9, -1, 0, 0);
    chk("vshort_verr_cnt", n_ve - b_e, 1);
    chk("vshort_verr_time", verr_cyc, tl[0] + 2);
    chk("vshort_no_herr", n_he - b_h, 0);
    frame(9, -1, 0, 0);
    chk("vshort_no_lock", 32'(locked), 0);
    frame(9, -1, 0, 0);
    chk("vshort_lock_time", lock_cyc, tl[0] + 2);

    // Sync loss: watchdog fires once at hcnt 1023.
    snap();
    idle(1100);
    chk("wd_herr_cnt", n_he - b_h, 1);
    chk("wd_herr_time", herr_cyc, t_idle + 1009);
    chk("wd_unlock", unlock_cyc, herr_cyc);
    chk("wd_locked", 32'(locked), 0);

    // Back from SEARCH: needs an h edge before the first clear counts.
    snap();
    frame(9, -1, 0, 0);
    frame(9, -1, 0, 0);
    frame(9, -1, 0, 0);
    chk("search_no_lock", 32'(locked), 0);
    frame(9, -1, 0, 0);
    chk("search_lock_time", lock_cyc, tl[0] + 2);
    chk("search_no_err", (n_he - b_h) + (n_ve - b_e), 0);

    // Reset in the middle of an active line.
    for (int l = 0; l < 5; l++) line(l, 16, 3);
    line(5, 10, 3);
    chk("pre_rst_state", 32'({locked, pix_valid}), 3);
    chk("pre_rst_xy", 32'({pix_x, pix_y}), 32'({10'd1, 10'd1}));
    reset = 1'b0;
    #1;
    chk("mid_rst_flags",
        32'({pix_valid, locked, frame_start, h_err, v_err}), 0);
    chk("mid_rst_xy", 32'({pix_x, pix_y}), 0);
    chk("mid_rst_rgb", 32'({pix_r, pix_g, pix_b}), 0);
    idle(3);
    reset = 1'b1;
    for (int l = 6; l < 9; l++) line(l, 16, 3);
    frame(9, -1, 0, 0);
    frame(9, -1, 0, 0);
    chk("post_rst_no_lock", 32'(locked), 0);
    snap();
    frame(9, -1, 0, 0);
    chk("post_rst_lock_time", lock_cyc, tl[0] + 2);
    chk("post_rst_valid", n_valid - b_v, 32);
    chk("post_rst_pix_bad", n_bad - b_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
